alu_sched: RTL and testbench



---
 rtl/alu_sched.sv | 141 ++++++++++++++
 tb/tb_alu_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Command FIFO and issue sequencer for the shared booth ALU.
// Issues one command at a time and returns the result or a timeout marker.
module alu_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_dtype,
  input  logic [4:0]               req_operator,
  input  logic [15:0]              req_src1,
  input  logic [15:0]              req_src2,
  output logic                     alu_start,
  output logic [3:0]               alu_dtype,
  output logic [4:0]               alu_operator,
  output logic [15:0]              alu_src1,
  output logic [15:0]              alu_src2,
  input  logic                     alu_done,
  input  logic [32:0]              alu_res,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [32:0]              res_data,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  state_t        state;
  logic          push;
  logic          pop;

  assign req_ready  = count != CW'(DEPTH);
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {req_dtype, req_operator, req_src1, req_src2};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      timer        <= '0;
      alu_start    <= 1'b0;
      alu_dtype    <= '0;
      alu_operator <= '0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            alu_dtype    <= head.dtype;
            alu_operator <= head.op;
            alu_src1     <= head.src1;
            alu_src2     <= head.src2;
            alu_start    <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          alu_start <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            res_data  <= alu_res;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: vector table plus
// hand-written sequences for fill, timeout, backpressure and reset.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dtype = '0;
  logic [4:0]  req_operator = '0;
  logic [15:0] req_src1 = '0;
  logic [15:0] req_src2 = '0;
  logic        alu_start;
  logic [3:0]  alu_dtype;
  logic [4:0]  alu_operator;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_done = 1'b0;
  logic [32:0] alu_res = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [32:0] res_data;
  logic        res_err;
  logic [2:0]  fifo_count;

  int n_pass = 0;
  int n_total = 0;

  alu_sched dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dtype    (req_dtype),
    .req_operator (req_operator),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .alu_start    (alu_start),
    .alu_dtype    (alu_dtype),
    .alu_operator (alu_operator),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_done     (alu_done),
    .alu_res      (alu_res),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [4:0]  op;
    logic [15:0] s1;
    logic [15:0] s2;
    int          dly;
    logic [32:0] res;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic push(logic [3:0] d, logic [4:0] op,
                      logic [15:0] s1, logic [15:0] s2);
    req_dtype    = d;
    req_operator = op;
    req_src1     = s1;
    req_src2     = s2;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_start(string nm);
    int n = 0;
    while (!alu_start && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_start_seen"}, 64'(alu_start), 64'd1);
  endtask

  // Entered either in ISSUE (alu_start high) or already in WAIT.
  task automatic serve(string nm, logic [15:0] s1, logic [32:0] r,
                       int dly, bit in_issue);
    chk({nm, "_src1"}, 64'(alu_src1), 64'(s1));
    if (in_issue) begin
      tick();
      chk({nm, "_pulse"}, 64'(alu_start), 64'd0);
    end
    repeat (dly) tick();
    chk({nm, "_early"}, 64'(res_valid), 64'd0);
    alu_done = 1'b1;
    alu_res  = r;
    tick();
    alu_done = 1'b0;
    alu_res  = '0;
    chk({nm, "_valid"}, 64'(res_valid), 64'd1);
    chk({nm, "_data"}, 64'(res_data), 64'(r));
    chk({nm, "_err"}, 64'(res_err), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({nm, "_accept"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fill [6];
    bit          ok;
    logic [32:0] held;

    vecs[0] = '{4'h1, 5'h03, 16'h0008, 16'h0002, 0, 33'h10, 33'h10};
    vecs[1] = '{4'h2, 5'h05, 16'hFFFF, 16'h0001, 2,
                33'h1_0000_FFFE, 33'h1_0000_FFFE};
    vecs[2] = '{4'hF, 5'h1F, 16'h1234, 16'hABCD, 5,
                33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF};
    vecs[3] = '{4'h0, 5'h00, 16'h0000, 16'h0000, 1, 33'h0, 33'h0};

    // Reset state
    #22;
    chk("rst_start", 64'(alu_start), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_err", 64'(res_err), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_src1", 64'(alu_src1), 64'd0);
    n_rst = 1'b1;
    tick();

    // Vector table: exact latency and field pass-through
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].d, vecs[i].op, vecs[i].s1, vecs[i].s2);
      chk($sformatf("v%0d_nostart", i), 64'(alu_start), 64'd0);
      tick();
      chk($sformatf("v%0d_start", i), 64'(alu_start), 64'd1);
      chk($sformatf("v%0d_dtype", i), 64'(alu_dtype), 64'(vecs[i].d));
      chk($sformatf("v%0d_op", i), 64'(alu_operator), 64'(vecs[i].op));
      chk($sformatf("v%0d_src2", i), 64'(alu_src2), 64'(vecs[i].s2));
      serve($sformatf("v%0d", i), vecs[i].s1, vecs[i].exp,
            vecs[i].dly, 1'b1);
      tick();
    end

    // Fill the FIFO behind a stalled ALU
    for (int i = 0; i < 6; i++) fill[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 5; i++) push(4'h1, 5'h03, fill[i], 16'h0);
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_ready", 64'(req_ready), 64'd0);
    push(4'h1, 5'h03, fill[5], 16'h0);
    chk("fill_nopush", 64'(fifo_count), 64'd4);
    chk("fill_inflight", 64'(alu_src1), 64'(fill[0]));
    serve("fill0", fill[0], 33'(fill[0]), 0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      wait_start($sformatf("fill%0d", i));
      serve($sformatf("fill%0d", i), fill[i], 33'(fill[i]), 1, 1'b1);
    end
    tick();
    chk("fill_empty", 64'(fifo_count), 64'd0);
    chk("fill_nosixth", 64'(alu_start), 64'd0);

    // Timeout: push at edge 0, error result after edge 66
    push(4'h3, 5'h07, 16'h00AA, 16'h0055);
    tick();
    chk("to_start", 64'(alu_start), 64'd1);
    repeat (64) tick();
    chk("to_e65", 64'(res_valid), 64'd0);
    tick();
    chk("to_valid", 64'(res_valid), 64'd1);
    chk("to_err", 64'(res_err), 64'd1);
    chk("to_data", 64'(res_data), 64'd0);
    alu_done = 1'b1;
    alu_res  = 33'h55;
    tick();
    alu_done = 1'b0;
    chk("to_late_data", 64'(res_data), 64'd0);
    chk("to_late_err", 64'(res_err), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    alu_res  = '0;
    chk("to_idle_valid", 64'(res_valid), 64'd0);
    chk("to_idle_start", 64'(alu_start), 64'd0);
    push(4'h1, 5'h03, 16'h0003, 16'h0005);
    wait_start("to_next");
    serve("to_next", 16'h0003, 33'hF, 0, 1'b1);
    tick();

    // Push/pop in IDLE with count 1, then backpressure
    push(4'h1, 5'h01, 16'h0101, 16'h0);
    push(4'h1, 5'h02, 16'h0202, 16'h0);
    chk("pp_count", 64'(fifo_count), 64'd1);
    chk("pp_start", 64'(alu_start), 64'd1);
    chk("pp_src1", 64'(alu_src1), 64'h0101);
    tick();
    alu_done = 1'b1;
    alu_res  = 33'h777;
    tick();
    alu_done = 1'b0;
    alu_res  = '0;
    held = res_data;
    chk("bp_data", 64'(held), 64'h777);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_data !== held || alu_start !== 1'b0 ||
          res_valid !== 1'b1 || fifo_count !== 3'd1)
        ok = 1'b0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_bubble", 64'(alu_start), 64'd0);
    tick();
    chk("bp_next_start", 64'(alu_start), 64'd1);
    serve("bp_next", 16'h0202, 33'h2, 0, 1'b1);
    tick();

    // Asynchronous reset while in WAIT with a queued command
    push(4'h1, 5'h03, 16'h0033, 16'h0);
    push(4'h1, 5'h03, 16'h0044, 16'h0);
    tick();
    chk("rw_queued", 64'(fifo_count), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rw_start", 64'(alu_start), 64'd0);
    chk("rw_valid", 64'(res_valid), 64'd0);
    chk("rw_count", 64'(fifo_count), 64'd0);
    chk("rw_ready", 64'(req_ready), 64'd1);
    chk("rw_src1", 64'(alu_src1), 64'd0);
    #2;
    n_rst = 1'b1;
    repeat (4) tick();
    chk("rw_noresult", 64'(res_valid), 64'd0);
    chk("rw_noissue", 64'(alu_start), 64'd0);
    push(4'h1, 5'h03, 16'h0003, 16'h0004);
    tick();
    chk("rw_mul_start", 64'(alu_start), 64'd1);
    serve("rw_mul", 16'h0003, 33'hC, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
